neuron_input_sequencer: RTL and testbench
=========================================

NEURON_INPUT_SEQUENCER -- requirements
Module: neuron_input_sequencer

Interface
REQ-001 SHALL have parameter LAYER_ID, default 0: value driven on o_layer_id.
REQ-002 SHALL have parameter NUM_NEURON, default 30: neurons addressed in the target layer.
REQ-003 SHALL have parameter NUM_INPUT, default 784: words per input vector.
REQ-004 SHALL have parameter DATA_WIDTH, default 16: activation word width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: ready-wait limit, used only with SEQ_TIMEOUT_EN.
REQ-006 SHALL have port i_clk, input, 1: clock; reset i_reset, synchronous, active-high.
REQ-007 SHALL have port i_reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port i_data, input, DATA_WIDTH: incoming vector word.
REQ-009 SHALL have port i_data_valid, input, 1: i_data qualifier.
REQ-010 SHALL have port o_data_ready, output, 1: buffer accepts a word.
REQ-011 SHALL have port i_neuron_ready, input, NUM_NEURON: per-neuron input-ready.
REQ-012 SHALL have port o_input, output, DATA_WIDTH: word broadcast to neurons.
REQ-013 SHALL have port o_input_valid, output, 1: single-cycle transfer strobe.
REQ-014 SHALL have port o_layer_id, output, 32: constant LAYER_ID.
REQ-015 SHALL have port o_neuron_id, output, 32: zero-extended index of addressed neuron.
REQ-016 SHALL have ports o_busy, o_done, o_error, output, 1 each: streaming in progress; vector-complete pulse; timeout flag.

Function
REQ-017 SHALL implement states S_LOAD, S_FETCH, S_WAIT_RDY, S_SEND, S_BLANK.
REQ-018 S_LOAD: o_data_ready=1; each i_data_valid&o_data_ready writes i_data to buffer address 0..NUM_INPUT-1 in order; the write at address NUM_INPUT-1 moves to S_FETCH with neuron index n=0 and word index k=0.
REQ-019 Buffer SHALL be NUM_INPUT x DATA_WIDTH synchronous RAM, one-cycle read latency; S_FETCH issues read of address k and lasts exactly one cycle, then S_WAIT_RDY.
REQ-020 S_WAIT_RDY: remain until i_neuron_ready[n]=1, then S_SEND.
REQ-021 S_SEND: exactly one cycle; o_input_valid=1, o_input=buffer[k], o_neuron_id=n; o_input holds its value until the next S_SEND.
REQ-022 S_BLANK: exactly 2 cycles with i_neuron_ready ignored (a neuron's ready stays high one cycle after acceptance); then advance.
REQ-023 Advance: k<NUM_INPUT-1 -> k+1, S_FETCH; k=NUM_INPUT-1 and n<NUM_NEURON-1 -> k=0, n+1, S_FETCH; both last -> o_done=1 for one cycle, S_LOAD.
REQ-024 Order: all NUM_INPUT words to neuron 0, then neuron 1, ..., no word skipped or repeated.
REQ-025 o_busy SHALL be 1 in every state except S_LOAD; o_data_ready SHALL be 0 outside S_LOAD.
REQ-026 i_data_valid outside S_LOAD SHALL be ignored and not stored.
REQ-027 o_layer_id SHALL equal LAYER_ID at all times, including reset.
REQ-028 Index counters SHALL be $clog2 width of their limits, compared against limits minus one (no wrap beyond limit).

Reset
REQ-029 i_reset SHALL force S_LOAD, n=k=0, write address 0, o_input=0, o_input_valid=0, o_neuron_id=0, o_done=0, o_error=0, o_busy=0, o_data_ready=1 on the next cycle.
REQ-030 Reset mid-load or mid-stream SHALL abandon the vector; buffer contents are not cleared and not used.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: a counter runs in S_WAIT_RDY, clears on entry; reaching TIMEOUT_CYCLES sets o_error=1 (sticky until reset) and returns to S_LOAD without o_done.
REQ-032 Macro SEQ_TIMEOUT_EN undefined: S_WAIT_RDY waits indefinitely; o_error tied 0; no counter logic.

Verification (NUM_NEURON=2, NUM_INPUT=3, DATA_WIDTH=16, LAYER_ID=1)
REQ-033 Load 0x0011,0x0022,0x0033, ready both high -> strobes (n,data): (0,0x11),(0,0x22),(0,0x33),(1,0x11),(1,0x22),(1,0x33), o_layer_id=1, then one-cycle o_done, o_data_ready=1.
REQ-034 Strobe spacing with ready always high -> consecutive o_input_valid pulses exactly 5 cycles apart (SEND,BLANK,BLANK,FETCH,WAIT).
REQ-035 Hold i_neuron_ready[1]=0 for 20 cycles after neuron 0 done -> no strobe during hold; first neuron-1 strobe one cycle after ready rises.
REQ-036 i_data_valid pulses during streaming with 0xFFFF -> ignored, streamed data unchanged, o_data_ready=0.
REQ-037 Assert i_reset after second strobe -> next cycle o_busy=0, o_data_ready=1, o_neuron_id=0; fresh vector 0x0A,0x0B,0x0C streams correctly.
REQ-038 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, i_neuron_ready=0 -> o_error=1 after 8 wait cycles, S_LOAD, no o_done; without macro -> waits, o_error=0.

Source files
------------

// File: rtl/neuron_input_sequencer.sv
// neuron_input_sequencer
// Buffers one input vector of NUM_INPUT words, then broadcasts it word by
// word to each of NUM_NEURON neurons in turn, waiting for the addressed
// neuron's ready before every transfer.
// Optional feature macro: SEQ_TIMEOUT_EN -- bounds the ready wait to
// TIMEOUT_CYCLES cycles and raises a sticky o_error when it expires.
module neuron_input_sequencer #(
  parameter int LAYER_ID       = 0,
  parameter int NUM_NEURON     = 30,
  parameter int NUM_INPUT      = 784,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [NUM_NEURON-1:0] i_neuron_ready,
  output logic [DATA_WIDTH-1:0] o_input,
  output logic                  o_input_valid,
  output logic [31:0]           o_layer_id,
  output logic [31:0]           o_neuron_id,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int K_W = (NUM_INPUT  > 1) ? $clog2(NUM_INPUT)  : 1;
  localparam int N_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_INPUT - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NUM_NEURON - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_WAIT_RDY,
    S_SEND,
    S_BLANK
  } state_t;

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [K_W-1:0]        waddr_q, waddr_d;
  logic [N_W-1:0]        n_q, n_d;
  logic                  blank_q, blank_d;
  logic [DATA_WIDTH-1:0] input_q, input_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  wr_en;
  logic                  tmo_hit;

  logic [DATA_WIDTH-1:0] mem [NUM_INPUT];
  logic [DATA_WIDTH-1:0] rd_data_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [T_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == T_W'(TIMEOUT_CYCLES - 1));

  // Ready-wait counter: held at zero outside S_WAIT_RDY so every entry starts fresh.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != S_WAIT_RDY) begin
      tmo_d = '0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Ready-wait counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // Without the timeout the wait is unbounded; the parameter is kept only
  // so both builds share one interface.
  logic unused_timeout;
  assign tmo_hit        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and datapath control for the load / stream sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    waddr_d = waddr_q;
    blank_d = blank_q;
    input_d = input_q;
    done_d  = 1'b0;
    error_d = error_q;
    wr_en   = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (i_data_valid) begin
          wr_en = 1'b1;
          if (waddr_q == K_LAST) begin
            waddr_d = '0;
            k_d     = '0;
            n_d     = '0;
            state_d = S_FETCH;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (i_neuron_ready[n_q]) begin
          input_d = rd_data_q;
          state_d = S_SEND;
        end else if (tmo_hit) begin
          error_d = 1'b1;
          k_d     = '0;
          n_d     = '0;
          waddr_d = '0;
          state_d = S_LOAD;
        end
      end
      S_SEND: begin
        blank_d = 1'b0;
        state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!blank_q) begin
          blank_d = 1'b1;
        end else if (k_q != K_LAST) begin
          k_d     = k_q + 1'b1;
          state_d = S_FETCH;
        end else if (n_q != N_LAST) begin
          k_d     = '0;
          n_d     = n_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          k_d     = '0;
          n_d     = '0;
          done_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      n_q     <= '0;
      waddr_q <= '0;
      blank_q <= 1'b0;
      input_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      waddr_q <= waddr_d;
      blank_q <= blank_d;
      input_q <= input_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Vector buffer: single write port during load, registered read issued in S_FETCH.
  always_ff @(posedge i_clk) begin
    // NOTE: the buffer has no reset; a fresh load always overwrites every
    // word before any is read, and a reset-free array maps onto RAM.
    if (wr_en) begin
      mem[waddr_q] <= i_data;
    end
    if (state_q == S_FETCH) begin
      rd_data_q <= mem[k_q];
    end
  end

  assign o_data_ready  = (state_q == S_LOAD);
  assign o_busy        = (state_q != S_LOAD);
  assign o_input_valid = (state_q == S_SEND);
  assign o_input       = input_q;
  assign o_neuron_id   = 32'(n_q);
  assign o_layer_id    = 32'(LAYER_ID);
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Self-checking bench for neuron_input_sequencer (NUM_NEURON=2, NUM_INPUT=3).
// Expected strobe order comes from a nested-loop reference model.
module tb_neuron_input_sequencer;

  localparam int NN = 2;
  localparam int NI = 3;
  localparam int DW = 16;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          o_data_ready;
  logic [NN-1:0] i_neuron_ready;
  logic [DW-1:0] o_input;
  logic          o_input_valid;
  logic [31:0]   o_layer_id;
  logic [31:0]   o_neuron_id;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  neuron_input_sequencer #(
    .LAYER_ID      (1),
    .NUM_NEURON    (NN),
    .NUM_INPUT     (NI),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .i_neuron_ready(i_neuron_ready),
    .o_input       (o_input),
    .o_input_valid (o_input_valid),
    .o_layer_id    (o_layer_id),
    .o_neuron_id   (o_neuron_id),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            n;
    logic [DW-1:0] d;
    int            cyc;
  } strobe_t;
  typedef strobe_t strobe_q_t[$];
  typedef logic [DW-1:0] vec_t [NI];

  strobe_t got[$];
  strobe_q_t exp_q;
  int cyc;
  int done_cnt;
  int viol;
  int passed;
  int total;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    cyc++;
    if (o_input_valid) got.push_back('{int'(o_neuron_id), o_input, cyc});
    if (o_done) done_cnt++;
    if (o_busy && o_data_ready) viol++;
  end

  // Reference: every word to neuron 0, then every word to neuron 1, ...
  function automatic strobe_q_t model(input vec_t v);
    strobe_q_t q;
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < NI; k++) q.push_back('{n, v[k], 0});
    return q;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset        = 1'b1;
    i_data_valid   = 1'b0;
    i_neuron_ready = '0;
    step();
    i_reset = 1'b0;
    got.delete();
    done_cnt = 0;
    viol     = 0;
  endtask

  task automatic load_vec(input vec_t v, input string name);
    for (int k = 0; k < NI; k++) begin
      i_data_valid = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      i_data       = v[k];
      i_data_valid = 1'b1;
      total++;
      if (o_data_ready !== 1'b1) $display("FAIL %s load_ready[%0d]: got %b expected 1", name, k, o_data_ready);
      else passed++;
      step();
    end
    i_data_valid = 1'b0;
  endtask

  // mode 0: all ready; 1: random ready; 2: random ready plus junk writes; 3: leave inputs
  task automatic wait_done(input int mode, input string name);
    for (int c = 0; c < 500 && done_cnt == 0; c++) begin
      if (mode == 0) i_neuron_ready = '1;
      if (mode == 1 || mode == 2) i_neuron_ready = NN'($urandom_range(0, 3));
      if (mode == 2) begin
        i_data       = 16'hFFFF;
        i_data_valid = 1'($urandom_range(0, 1));
      end
      step();
    end
    i_data_valid = 1'b0;
    step();
    total++;
    if (done_cnt !== 1) $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    else passed++;
  endtask

  task automatic cmp_stream(input vec_t v, input string name);
    exp_q = model(v);
    total++;
    if (got.size() != exp_q.size()) $display("FAIL %s strobe_count: got %0d expected %0d", name, got.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i].n !== exp_q[i].n || got[i].d !== exp_q[i].d)
        $display("FAIL %s strobe[%0d]: got n=%0d d=%h expected n=%0d d=%h", name, i, got[i].n, got[i].d, exp_q[i].n, exp_q[i].d);
      else passed++;
    end
  endtask

  task automatic test_reset();
    i_reset        = 1'b1;
    i_data         = '0;
    i_data_valid   = 1'b0;
    i_neuron_ready = '0;
    step();
    step();
    total++;
    if ({o_busy, o_data_ready, o_input_valid, o_done, o_error} !== 5'b01000)
      $display("FAIL reset_flags: got %b expected 01000", {o_busy, o_data_ready, o_input_valid, o_done, o_error});
    else passed++;
    total++;
    if (o_input !== '0 || o_neuron_id !== 32'd0) $display("FAIL reset_data: got in=%h id=%0d expected 0 0", o_input, o_neuron_id);
    else passed++;
    total++;
    if (o_layer_id !== 32'd1) $display("FAIL reset_layer_id: got %0d expected 1", o_layer_id);
    else passed++;
    do_reset();
  endtask

  task automatic test_basic();
    vec_t v = '{16'h0011, 16'h0022, 16'h0033};
    do_reset();
    load_vec(v, "basic");
    wait_done(0, "basic");
    cmp_stream(v, "basic");
    for (int i = 1; i < got.size(); i++) begin
      total++;
      if (got[i].cyc - got[i-1].cyc !== 5) $display("FAIL basic spacing[%0d]: got %0d expected 5", i, got[i].cyc - got[i-1].cyc);
      else passed++;
    end
    total++;
    if (o_data_ready !== 1'b1 || o_busy !== 1'b0 || o_layer_id !== 32'd1)
      $display("FAIL basic idle_after: got rdy=%b busy=%b layer=%0d expected 1 0 1", o_data_ready, o_busy, o_layer_id);
    else passed++;
  endtask

  task automatic test_random();
    vec_t v;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NI; k++) v[k] = DW'($urandom);
      do_reset();
      load_vec(v, "random");
      wait_done(1, "random");
      cmp_stream(v, "random");
    end
  endtask

  task automatic test_ready_hold();
    vec_t v = '{16'h1234, 16'h5678, 16'h9ABC};
    int rise;
    do_reset();
    i_neuron_ready = 2'b01;
    load_vec(v, "hold");
    for (int c = 0; c < 100 && got.size() < NI; c++) step();
    repeat (20) step();
    total++;
    if (got.size() !== NI) $display("FAIL hold no_strobe: got %0d strobes expected %0d", got.size(), NI);
    else passed++;
    i_neuron_ready = 2'b11;
    rise = cyc + 1;
    wait_done(3, "hold");
    cmp_stream(v, "hold");
    if (got.size() > NI) begin
      total++;
      if (got[NI].cyc !== rise + 1) $display("FAIL hold rise_latency: got %0d expected %0d", got[NI].cyc - rise, 1);
      else passed++;
    end
  endtask

  task automatic test_ignore_valid();
    vec_t v;
    for (int k = 0; k < NI; k++) v[k] = DW'($urandom_range(0, 16'hFFFE));
    do_reset();
    load_vec(v, "ignore");
    wait_done(2, "ignore");
    cmp_stream(v, "ignore");
    total++;
    if (viol !== 0) $display("FAIL ignore ready_while_busy: got %0d cycles expected 0", viol);
    else passed++;
  endtask

  task automatic test_reset_mid();
    vec_t v  = '{16'h0111, 16'h0222, 16'h0333};
    vec_t v2 = '{16'h000A, 16'h000B, 16'h000C};
    do_reset();
    load_vec(v, "midrst");
    i_neuron_ready = 2'b11;
    for (int c = 0; c < 100 && got.size() < 2; c++) step();
    i_reset = 1'b1;
    step();
    total++;
    if (o_busy !== 1'b0 || o_data_ready !== 1'b1 || o_neuron_id !== 32'd0 || o_input_valid !== 1'b0)
      $display("FAIL midrst after_reset: got busy=%b rdy=%b id=%0d v=%b expected 0 1 0 0", o_busy, o_data_ready, o_neuron_id, o_input_valid);
    else passed++;
    i_reset = 1'b0;
    got.delete();
    done_cnt = 0;
    load_vec(v2, "midrst");
    wait_done(0, "midrst");
    cmp_stream(v2, "midrst");
  endtask

  task automatic test_timeout();
    vec_t v = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    do_reset();
    load_vec(v, "timeout");
    i_neuron_ready = '0;
    repeat (40) step();
    total++;
    if (got.size() !== 0 || done_cnt !== 0) $display("FAIL timeout no_activity: got strobes=%0d done=%0d expected 0 0", got.size(), done_cnt);
    else passed++;
`ifdef SEQ_TIMEOUT_EN
    total++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_data_ready !== 1'b1)
      $display("FAIL timeout flags: got err=%b busy=%b rdy=%b expected 1 0 1", o_error, o_busy, o_data_ready);
    else passed++;
`else
    total++;
    if (o_error !== 1'b0 || o_busy !== 1'b1 || o_data_ready !== 1'b0)
      $display("FAIL timeout flags: got err=%b busy=%b rdy=%b expected 0 1 0", o_error, o_busy, o_data_ready);
    else passed++;
`endif
    do_reset();
    total++;
    if (o_error !== 1'b0) $display("FAIL timeout error_cleared: got %b expected 0", o_error);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    cyc    = 0;
    test_reset();
    test_basic();
    test_random();
    test_ready_hold();
    test_ignore_valid();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
